// File: rtl/pd_pkg.sv
// ============================================================================
// Module      : pd_pkg
// Description : Shared types and defaults for the pulse-period front end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        STALE = 2'd2
    } pd_state_t;

    localparam int DIV_DEFAULT      = 1_000_000;
    localparam int FILT_LEN_DEFAULT = 4;
    localparam int QW_DEFAULT       = 8;
    localparam int QMAX             = 2**QW_DEFAULT - 1;

endpackage

`default_nettype wire

// File: rtl/pd_counter.sv
// ============================================================================
// Module      : pd_counter
// Description : Saturating period counter cleared by clr, advanced by enb.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pd_counter
    import pd_pkg::*;
#(
    parameter int QW = QW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          enb,
    output logic [QW-1:0] q
);

    localparam logic [QW-1:0] c_qsat = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (enb && (q != c_qsat)) begin
            q <= q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pulse_filter.sv
// ============================================================================
// Module      : pulse_filter
// Description : Two-flop synchroniser, run-length de-glitch filter and rising
//               edge detector for the raw pulse input.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_filter
    import pd_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level,
    output logic rise
);

    localparam int                c_cw       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_cw-1:0]   c_run_last = c_cw'(FILT_LEN - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_level_d;
    logic [c_cw-1:0] r_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            level     <= 1'b0;
            r_level_d <= 1'b0;
            r_run     <= '0;
        end else begin
            r_s1      <= pulse_in;
            r_s2      <= r_s1;
            r_level_d <= level;
            // A single agreeing sample restarts the run, so glitches never accumulate.
            if (r_s2 == level) begin
                r_run <= '0;
            end else if (r_run == c_run_last) begin
                level <= ~level;
                r_run <= '0;
            end else begin
                r_run <= r_run + 1'b1;
            end
        end
    end

    assign rise = level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/pd_control.sv
// ============================================================================
// Module      : pd_control
// Description : Pulse-period front end: prescaler, measurement FSM and period
//               capture register around the pulse_filter edge detector.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pd_control
    import pd_pkg::*;
#(
    parameter int DIV      = DIV_DEFAULT,
    parameter int FILT_LEN = FILT_LEN_DEFAULT,
    parameter int QW       = QW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    input  logic [QW-1:0] q,
    output logic          enb,
    output logic          clr,
    output logic          cap,
    output logic [QW-1:0] period,
    output logic          period_valid,
    output logic          timeout
);

    localparam int              c_pw       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_pw-1:0] c_pre_last = c_pw'(DIV - 1);
    localparam logic [QW-1:0]   c_qsat     = '1;

    pd_state_t       r_state;
    logic [c_pw-1:0] r_pre;
    logic            w_level;
    logic            w_rise;
    logic            w_edge;
    logic            w_sat;
    logic            w_clr_next;

    pulse_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .level    (w_level),
        .rise     (w_rise)
    );

    assign w_edge = w_rise & w_level;
    // q still holds the old count during a clr cycle, so it cannot signal saturation then.
    assign w_sat  = (q == c_qsat) && !clr;

    always_comb begin
        w_clr_next = 1'b0;
        case (r_state)
            IDLE:    w_clr_next = w_edge;
            ARMED:   w_clr_next = w_edge && !w_sat;
            STALE:   w_clr_next = w_edge;
            default: w_clr_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pre        <= '0;
            enb          <= 1'b0;
            clr          <= 1'b0;
            cap          <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            clr   <= w_clr_next;
            cap   <= w_clr_next && (r_state == ARMED);
            enb   <= (r_state != IDLE) && !w_clr_next && (r_pre == c_pre_last);
            r_pre <= (w_clr_next || (r_pre == c_pre_last)) ? '0 : r_pre + 1'b1;

            // q is sampled in the cap cycle itself, before the counter clears.
            if (cap) begin
                period       <= q;
                period_valid <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_edge) r_state <= ARMED;
                end
                ARMED: begin
                    if (w_sat) begin
                        r_state      <= STALE;
                        timeout      <= 1'b1;
                        period_valid <= 1'b0;
                    end
                end
                STALE: begin
                    if (w_edge) begin
                        r_state <= ARMED;
                        timeout <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pd_control.sv
// ============================================================================
// Module      : tb_pd_control
// Description : Scoreboard bench for pd_control + pd_counter (DIV=4 and DIV=1).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pd_control;

    localparam int QMAX  = pd_pkg::QMAX;
    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_STALE = 2;

    typedef struct {
        int cyc;
        bit is_to;
        bit cap;
        int q;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse [2];
    logic       enb_s [2];
    logic       clr_s [2];
    logic       cap_s [2];
    logic       pv_s  [2];
    logic       to_s  [2];
    logic [7:0] per_s [2];
    logic [7:0] q_s   [2];

    int  cyc    = 0;
    bit  mon_on = 0;
    bit  done   = 0;
    bit  drained = 0;
    int  n_cmp  = 0;
    int  n_fail = 0;

    ev_t expq [2][$];
    int  m_state [2] = '{S_IDLE, S_IDLE};
    int  m_last  [2] = '{0, 0};

    int  rd      [2] = '{0, 0};
    bit  m_armed [2] = '{0, 0};
    int  m_lastc [2] = '{0, 0};
    bit  m_to    [2] = '{0, 0};
    bit  m_val   [2] = '{0, 0};
    int  m_per   [2] = '{0, 0};
    bit  m_pend  [2] = '{0, 0};
    int  m_pq    [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pd_control #(
            .DIV      ((gi == 0) ? 4 : 1),
            .FILT_LEN (3),
            .QW       (8)
        ) u_ctl (
            .clk          (clk),
            .rst          (rst),
            .pulse_in     (pulse[gi]),
            .q            (q_s[gi]),
            .enb          (enb_s[gi]),
            .clr          (clr_s[gi]),
            .cap          (cap_s[gi]),
            .period       (per_s[gi]),
            .period_valid (pv_s[gi]),
            .timeout      (to_s[gi])
        );
        pd_counter #(
            .QW (8)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr_s[gi]),
            .enb (enb_s[gi]),
            .q   (q_s[gi])
        );
    end

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic void chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0d expected=%0d", nm, i, cyc, act, exp);
        end
    endfunction

    // ---------------- reference model (event level) ----------------
    // Saturation is first visible on q at last_clr + QMAX*DIV + 1; timeout follows one cycle later.
    task automatic predict(input int i, input int limit);
        ev_t e;
        int  s;
        if (m_state[i] == S_ARMED) begin
            s = m_last[i] + QMAX * div_of(i) + 1;
            if (s <= limit) begin
                e.cyc = s + 1; e.is_to = 1; e.cap = 0; e.q = 0;
                expq[i].push_back(e);
                m_state[i] = S_STALE;
            end
        end
    endtask

    task automatic step(input int k);
        predict(0, cyc + k);
        predict(1, cyc + k);
        repeat (k) @(negedge clk);
    endtask

    // A clean rise driven at cycle n produces clr at n + FILT_LEN + 3.
    task automatic do_rise(input int i, input int hi, input int lo);
        ev_t e;
        int  n;
        int  t;
        bit  coincide;
        n = cyc;
        coincide = (m_state[i] == S_ARMED) &&
                   (m_last[i] + QMAX * div_of(i) + 1 == n + 5);
        predict(i, n + 5);
        if (!coincide) begin
            e.cyc = n + 6; e.is_to = 0; e.cap = 0; e.q = 0;
            if (m_state[i] == S_ARMED) begin
                t     = e.cyc - m_last[i];
                e.cap = 1;
                e.q   = ((t - 1) / div_of(i) > QMAX) ? QMAX : (t - 1) / div_of(i);
            end
            expq[i].push_back(e);
            m_state[i] = S_ARMED;
            m_last[i]  = e.cyc;
        end
        pulse[i] = 1'b1;
        step(hi);
        pulse[i] = 1'b0;
        step(lo);
    endtask

    task automatic do_glitch(input int i, input int lo);
        pulse[i] = 1'b1;
        step(2);
        pulse[i] = 1'b0;
        step(lo);
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        m_state[0] = S_IDLE;
        m_state[1] = S_IDLE;
        repeat (k) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        #1;
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                ev_t e;
                bit  hit;
                bit  enb_exp;
                if (m_pend[i]) begin
                    m_per[i]  = m_pq[i];
                    m_val[i]  = 1'b1;
                    m_pend[i] = 1'b0;
                end
                hit = (rd[i] < expq[i].size()) && (expq[i][rd[i]].cyc == cyc);
                if (hit) begin
                    e = expq[i][rd[i]];
                    rd[i]++;
                    if (e.is_to) begin
                        m_to[i]  = 1'b1;
                        m_val[i] = 1'b0;
                    end else begin
                        chk("clr", i, int'(clr_s[i]), 1);
                        chk("cap", i, int'(cap_s[i]), int'(e.cap));
                        if (e.cap) begin
                            chk("q_at_cap", i, int'(q_s[i]), e.q);
                            m_pend[i] = 1'b1;
                            m_pq[i]   = e.q;
                        end
                        m_armed[i] = 1'b1;
                        m_lastc[i] = cyc;
                        m_to[i]    = 1'b0;
                    end
                end
                if (!hit || e.is_to)
                    chk("no_clr_cap", i, int'({clr_s[i], cap_s[i]}), 0);
                enb_exp = m_armed[i] && (cyc != m_lastc[i]) &&
                          (((cyc - m_lastc[i]) % div_of(i)) == 0);
                chk("enb", i, int'(enb_s[i]), int'(enb_exp));
                chk("timeout", i, int'(to_s[i]), int'(m_to[i]));
                chk("period_valid", i, int'(pv_s[i]), int'(m_val[i]));
                chk("period", i, int'(per_s[i]), m_per[i]);
                if (rst) begin
                    m_armed[i] = 1'b0;
                    m_to[i]    = 1'b0;
                    m_val[i]   = 1'b0;
                    m_per[i]   = 0;
                    m_pend[i]  = 1'b0;
                end
            end
            if (done && !drained) begin
                for (int i = 0; i < 2; i++)
                    chk("events_drained", i, rd[i], expq[i].size());
                drained = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        pulse[0] = 1'b0;
        pulse[1] = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        mon_on   = 1'b1;
        pulse[0] = 1'b1; pulse[1] = 1'b1;
        @(negedge clk);
        pulse[0] = 1'b0; pulse[1] = 1'b0;
        rst      = 1'b0;
        step(10);

        // DIV=4: first edge arms, then 40-cycle period
        do_rise(0, 10, 30);
        do_rise(0, 10, 30);
        do_rise(0, 10, 20);
        // glitch between real edges must be ignored
        do_glitch(0, 15);
        do_rise(0, 10, 20);
        for (int k = 0; k < 8; k++)
            do_rise(0, 5 + int'($urandom_range(15)), 8 + int'($urandom_range(290)));

        // reset mid-count in ARMED
        step(25);
        do_reset(1);
        step(10);
        do_rise(0, 10, 30);
        do_rise(0, 10, 30);

        // DIV=1: arm, starve into timeout, re-arm, then a 50-cycle period
        do_rise(1, 10, 10);
        do_rise(1, 10, 300);
        do_rise(1, 10, 40);
        do_rise(1, 10, 40);
        for (int k = 0; k < 6; k++)
            do_rise(1, 5 + int'($urandom_range(15)), 8 + int'($urandom_range(180)));

        step(20);
        done = 1'b1;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
